// File: rtl/ram_rb_pkg.sv
// Shared definitions for the row/column burst matrix RAM (ram_rowcol_burst).
// Contents: FSM state enum, burst mode encodings, default geometry and a lane-slice helper.
package ram_rb_pkg;

  // Default geometry, shared with define.vh users.
  localparam int unsigned DATA_W_DEF = 16;
  localparam int unsigned LANES_DEF  = 8;
  localparam int unsigned ROWS_DEF   = 8;

  // Burst read mode encodings.
  localparam logic MODE_ROW = 1'b0;
  localparam logic MODE_COL = 1'b1;

  typedef enum logic [0:0] {
    StClear,
    StIdle
  } rb_state_e;

  // LSB position of lane 'lane' inside a packed burst of 'data_w'-bit words.
  function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned data_w);
    return lane * data_w;
  endfunction

endpackage

// File: rtl/ram_rb_lane_sel.sv
// Burst address generator for ram_rowcol_burst.
// Turns a row index (MODE_ROW) or column index (MODE_COL) into LANES word addresses,
// packed lane 0 in the low bits, and flags an index that falls outside the matrix.
// Addresses are forced to zero when the index is out of range.
module ram_rb_lane_sel
  import ram_rb_pkg::*;
#(
  parameter int unsigned LANES  = LANES_DEF,
  parameter int unsigned ROWS   = ROWS_DEF,
  parameter int unsigned IDX_W  = $clog2(ROWS + 1),
  parameter int unsigned MEM_AW = $clog2(ROWS * LANES)
) (
  input  logic                    mode,
  input  logic [IDX_W-1:0]        ra,
  output logic [LANES*MEM_AW-1:0] addrs,
  output logic                    oor
);

  // Range check and per-lane word address generation.
  always_comb begin
    addrs = '0;
    if (mode == MODE_ROW) begin
      oor = (ra >= IDX_W'(ROWS));
    end else begin
      oor = (ra >= IDX_W'(LANES));
    end
    if (!oor) begin
      for (int unsigned i = 0; i < LANES; i++) begin
        if (mode == MODE_ROW) begin
          addrs[i*MEM_AW +: MEM_AW] = MEM_AW'(32'(ra) * LANES + i);
        end else begin
          addrs[i*MEM_AW +: MEM_AW] = MEM_AW'(i * LANES + 32'(ra));
        end
      end
    end
  end

endmodule

// File: rtl/ram_rowcol_burst.sv
// Matrix RAM (ROWS x LANES words) for the OMP R-matrix store.
// Single-word write port; burst read port returning a full row or a full column per access,
// registered with a valid flag. Out-of-range accesses are rejected with a one-cycle ERR pulse.
// After reset the array is zeroed one row per cycle before READY rises.
// Build option: define RAM_RB_WRITE_FWD_EN to forward same-cycle write data into a read burst
// (write-through); otherwise reads return pre-write data.
module ram_rowcol_burst
  import ram_rb_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned LANES  = LANES_DEF,
  parameter int unsigned ROWS   = ROWS_DEF,
  // One spare code point above the last valid address/index so rejected accesses are encodable.
  parameter int unsigned ADDR_W = $clog2(ROWS * LANES + 1),
  parameter int unsigned IDX_W  = $clog2(ROWS + 1)
) (
  input  logic                    CK,
  input  logic                    RST_N,
  input  logic                    WE,
  input  logic [ADDR_W-1:0]       A,
  input  logic [DATA_W-1:0]       D,
  input  logic                    RE,
  input  logic                    MODE,
  input  logic [IDX_W-1:0]        RA,
  input  logic                    OE,
  output logic                    READY,
  output logic                    Q_VALID,
  output logic                    ERR,
  output logic [LANES*DATA_W-1:0] Q
);

  localparam int unsigned WORDS  = ROWS * LANES;
  localparam int unsigned MEM_AW = $clog2(WORDS);

  logic [DATA_W-1:0] mem [WORDS];

  rb_state_e               state_q, state_d;
  logic [IDX_W-1:0]        ptr_q, ptr_d;
  logic [LANES*DATA_W-1:0] q_q, q_d;
  logic                    q_valid_q, q_valid_d;
  logic                    err_q, err_d;

  logic [LANES*MEM_AW-1:0] rd_addrs;
  logic                    rd_oor;
  logic                    idle;
  logic                    wr_oor;
  logic                    wr_ok;
  logic [MEM_AW-1:0]       wr_addr;

  ram_rb_lane_sel #(
    .LANES  (LANES),
    .ROWS   (ROWS),
    .IDX_W  (IDX_W),
    .MEM_AW (MEM_AW)
  ) u_lane_sel (
    .mode  (MODE),
    .ra    (RA),
    .addrs (rd_addrs),
    .oor   (rd_oor)
  );

  assign idle    = (state_q == StIdle);
  assign wr_oor  = (A >= ADDR_W'(WORDS));
  assign wr_addr = A[MEM_AW-1:0];
  assign wr_ok   = idle & WE & ~wr_oor;

  // FSM next state: walk the clear pointer over all rows, then settle in idle.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      StClear: begin
        if (ptr_q == IDX_W'(ROWS - 1)) begin
          state_d = StIdle;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + IDX_W'(1);
        end
      end
      StIdle: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StClear;
        ptr_d   = '0;
      end
    endcase
  end

  // Read result and error next state; requests outside idle are ignored.
  always_comb begin
    q_d       = q_q;
    q_valid_d = q_valid_q;
    // Write and read violations in the same cycle merge into a single pulse.
    err_d     = idle & ((WE & wr_oor) | (RE & rd_oor));
    if (idle && RE) begin
      if (rd_oor) begin
        q_d       = '0;
        q_valid_d = 1'b0;
      end else begin
        q_valid_d = 1'b1;
        for (int unsigned i = 0; i < LANES; i++) begin
          // The array is read before this edge's write lands, giving read-before-write.
          q_d[lane_lsb(i, DATA_W) +: DATA_W] = mem[rd_addrs[i*MEM_AW +: MEM_AW]];
`ifdef RAM_RB_WRITE_FWD_EN
          if (wr_ok && (wr_addr == rd_addrs[i*MEM_AW +: MEM_AW])) begin
            q_d[lane_lsb(i, DATA_W) +: DATA_W] = D;
          end
`endif
        end
      end
    end
  end

  // State, clear pointer and registered read result.
  always_ff @(posedge CK) begin
    if (!RST_N) begin
      state_q   <= StClear;
      ptr_q     <= '0;
      q_q       <= '0;
      q_valid_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      q_q       <= q_d;
      q_valid_q <= q_valid_d;
      err_q     <= err_d;
    end
  end

  // Storage: zero row ptr_q while clearing, accept in-range single-word writes when idle.
  always_ff @(posedge CK) begin
    if (RST_N) begin
      if (state_q == StClear) begin
        for (int unsigned i = 0; i < LANES; i++) begin
          mem[MEM_AW'(32'(ptr_q) * LANES + i)] <= '0;
        end
      end else if (wr_ok) begin
        mem[wr_addr] <= D;
      end
    end
  end

  assign READY   = idle;
  assign Q_VALID = q_valid_q;
  assign ERR     = err_q;
  // Output enable only gates the bus; it never touches stored state.
  assign Q       = OE ? q_q : {(LANES*DATA_W){1'bz}};

endmodule

// File: tb/tb_ram_rowcol_burst.sv
// Self-checking bench for ram_rowcol_burst with a word-array reference model.
module tb_ram_rowcol_burst;

  localparam int unsigned DW    = 16;
  localparam int unsigned LN    = 8;
  localparam int unsigned RW    = 8;
  localparam int unsigned AW    = 7;
  localparam int unsigned IW    = 4;
  localparam int unsigned QW    = LN * DW;
  localparam int unsigned WORDS = RW * LN;

  logic          ck = 1'b0;
  logic          rst_n = 1'b0;
  logic          we = 1'b0;
  logic [AW-1:0] a = '0;
  logic [DW-1:0] d = '0;
  logic          re = 1'b0;
  logic          mode = 1'b0;
  logic [IW-1:0] ra = '0;
  logic          oe = 1'b1;
  logic          ready;
  logic          q_valid;
  logic          err;
  wire  [QW-1:0] q;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state.
  logic [DW-1:0] m_mem [WORDS];
  logic [QW-1:0] m_q;
  logic          m_qv;
  logic          m_err;

  always #5 ck = ~ck;

  ram_rowcol_burst dut (
    .CK      (ck),
    .RST_N   (rst_n),
    .WE      (we),
    .A       (a),
    .D       (d),
    .RE      (re),
    .MODE    (mode),
    .RA      (ra),
    .OE      (oe),
    .READY   (ready),
    .Q_VALID (q_valid),
    .ERR     (err),
    .Q       (q)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    for (int i = 0; i < int'(WORDS); i++) m_mem[i] = '0;
    m_q   = '0;
    m_qv  = 1'b0;
    m_err = 1'b0;
  endtask

  // Expected effect of one idle-state clock edge.
  task automatic model_op(input logic w, input int unsigned wa, input logic [DW-1:0] wd,
                          input logic r, input logic md, input int unsigned ri);
    logic        bad_w;
    logic        bad_r;
    int unsigned addr;
    bad_w = w && (wa >= WORDS);
    bad_r = r && (md ? (ri >= LN) : (ri >= RW));
    m_err = bad_w || bad_r;
    if (r) begin
      if (bad_r) begin
        m_q  = '0;
        m_qv = 1'b0;
      end else begin
        m_qv = 1'b1;
        for (int unsigned i = 0; i < LN; i++) begin
          addr = md ? (i * LN + ri) : (ri * LN + i);
          m_q[i*DW +: DW] = m_mem[addr];
`ifdef RAM_RB_WRITE_FWD_EN
          if (w && !bad_w && (wa == addr)) m_q[i*DW +: DW] = wd;
`endif
        end
      end
    end
    if (w && !bad_w) m_mem[wa] = wd;
  endtask

  task automatic do_op(input logic w, input int unsigned wa, input logic [DW-1:0] wd,
                       input logic r, input logic md, input int unsigned ri);
    we   = w;
    a    = AW'(wa);
    d    = wd;
    re   = r;
    mode = md;
    ra   = IW'(ri);
    model_op(w, wa, wd, r, md, ri);
    @(posedge ck);
    #1;
    we = 1'b0;
    re = 1'b0;
  endtask

  task automatic test_reset();
    int cnt;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge ck);
    #1;
    n_cmp++;
    if ({ready, q_valid, err} !== 3'b000) begin
      n_bad++;
      $display("FAIL reset_outputs: got rdy/qv/err=%b required 000", {ready, q_valid, err});
    end
    n_cmp++;
    if (q !== '0) begin
      n_bad++;
      $display("FAIL reset_q: got %h required 0", q);
    end
    rst_n = 1'b1;
    // Out-of-range requests during the clear sweep must be ignored silently.
    we = 1'b1; a = AW'(64); re = 1'b1; mode = 1'b0; ra = IW'(8);
    cnt = 0;
    while (!ready && cnt < 20) begin
      @(posedge ck);
      #1;
      cnt++;
      n_cmp++;
      if (err !== 1'b0 || q_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL clear_quiet: got err=%b qv=%b required 0 0", err, q_valid);
      end
    end
    we = 1'b0; re = 1'b0;
    n_cmp++;
    if (cnt != 8) begin
      n_bad++;
      $display("FAIL clear_length: got %0d cycles required 8", cnt);
    end
    do_op(1'b0, 0, '0, 1'b1, 1'b0, 3);
    n_cmp++;
    if (q !== '0 || q_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_read: got q=%h qv=%b required 0 1", q, q_valid);
    end
  endtask

  task automatic test_row_read();
    for (int unsigned i = 0; i < LN; i++) do_op(1'b1, 2 * LN + i, DW'(16'h0100 + i), 1'b0, 1'b0, 0);
    do_op(1'b0, 0, '0, 1'b1, 1'b0, 2);
    for (int unsigned i = 0; i < LN; i++) begin
      n_cmp++;
      if (q[i*DW +: DW] !== DW'(16'h0100 + i) || q_valid !== 1'b1) begin
        n_bad++;
        $display("FAIL row_read lane%0d: got %h qv=%b required %h 1", i, q[i*DW +: DW], q_valid,
                 DW'(16'h0100 + i));
      end
    end
  endtask

  task automatic test_col_read();
    for (int unsigned r = 0; r < RW; r++) do_op(1'b1, r * LN + 5, DW'(16'h0A00 + r), 1'b0, 1'b0, 0);
    do_op(1'b0, 0, '0, 1'b1, 1'b1, 5);
    for (int unsigned r = 0; r < LN; r++) begin
      n_cmp++;
      if (q[r*DW +: DW] !== DW'(16'h0A00 + r)) begin
        n_bad++;
        $display("FAIL col_read lane%0d: got %h required %h", r, q[r*DW +: DW], DW'(16'h0A00 + r));
      end
    end
    repeat (3) do_op(1'b0, 0, '0, 1'b0, 1'b0, 0);
    n_cmp++;
    if (q !== m_q || q_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL col_hold: got %h qv=%b required %h 1", q, q_valid, m_q);
    end
  endtask

  task automatic test_range_err();
    do_op(1'b1, 64, 16'hDEAD, 1'b0, 1'b0, 0);
    n_cmp++;
    if (err !== 1'b1) begin
      n_bad++;
      $display("FAIL wr_oor_err: got %b required 1", err);
    end
    do_op(1'b0, 0, '0, 1'b0, 1'b0, 0);
    n_cmp++;
    if (err !== 1'b0) begin
      n_bad++;
      $display("FAIL err_pulse_end: got %b required 0", err);
    end
    do_op(1'b0, 0, '0, 1'b1, 1'b0, 0);
    n_cmp++;
    if (q !== m_q) begin
      n_bad++;
      $display("FAIL wr_oor_mem: got %h required %h", q, m_q);
    end
    do_op(1'b0, 0, '0, 1'b1, 1'b0, 8);
    n_cmp++;
    if (err !== 1'b1 || q_valid !== 1'b0 || q !== '0) begin
      n_bad++;
      $display("FAIL rd_oor: got err=%b qv=%b q=%h required 1 0 0", err, q_valid, q);
    end
    do_op(1'b1, 64, 16'h5555, 1'b1, 1'b1, 8);
    n_cmp++;
    if (err !== 1'b1) begin
      n_bad++;
      $display("FAIL both_oor_err: got %b required 1", err);
    end
    do_op(1'b0, 0, '0, 1'b0, 1'b0, 0);
    n_cmp++;
    if (err !== 1'b0) begin
      n_bad++;
      $display("FAIL both_oor_single: got %b required 0", err);
    end
  endtask

  task automatic test_collision();
    logic [DW-1:0] exp_lane;
`ifdef RAM_RB_WRITE_FWD_EN
    exp_lane = 16'h2222;
`else
    exp_lane = 16'h1111;
`endif
    do_op(1'b1, 9, 16'h1111, 1'b0, 1'b0, 0);
    do_op(1'b1, 9, 16'h2222, 1'b1, 1'b0, 1);
    n_cmp++;
    if (q[DW +: DW] !== exp_lane || q !== m_q) begin
      n_bad++;
      $display("FAIL collision: got lane1=%h q=%h required %h %h", q[DW +: DW], q, exp_lane, m_q);
    end
    do_op(1'b0, 0, '0, 1'b1, 1'b0, 1);
    n_cmp++;
    if (q[DW +: DW] !== 16'h2222) begin
      n_bad++;
      $display("FAIL collision_reread: got %h required 2222", q[DW +: DW]);
    end
  endtask

  task automatic test_random();
    logic        w, r, md;
    int unsigned wa, ri;
    for (int n = 0; n < 300; n++) begin
      w  = 1'($urandom_range(0, 1));
      r  = 1'($urandom_range(0, 1));
      md = 1'($urandom_range(0, 1));
      ri = ($urandom_range(0, 15) == 0) ? 8 : $urandom_range(0, 7);
      wa = ($urandom_range(0, 15) == 0) ? 64 : $urandom_range(0, 63);
      // Aim some writes into the burst being read to exercise collisions.
      if (ri < 8 && $urandom_range(0, 3) == 0) begin
        wa = md ? ($urandom_range(0, 7) * LN + ri) : (ri * LN + $urandom_range(0, 7));
      end
      do_op(w, wa, DW'($urandom), r, md, ri);
      n_cmp++;
      if (q !== m_q || q_valid !== m_qv || err !== m_err) begin
        n_bad++;
        $display("FAIL random[%0d]: got q=%h qv=%b err=%b required %h %b %b", n, q, q_valid, err,
                 m_q, m_qv, m_err);
      end
    end
  endtask

  task automatic test_oe();
    do_op(1'b0, 0, '0, 1'b1, 1'b0, 2);
    oe = 1'b0;
    #1;
    n_cmp++;
    // Two-state simulators resolve an undriven bus to zero rather than z.
    if (!(q === {QW{1'bz}} || q === '0) || (m_q != '0 && q === m_q)) begin
      n_bad++;
      $display("FAIL oe_off: got %h required all z", q);
    end
    oe = 1'b1;
    #1;
    n_cmp++;
    if (q !== m_q) begin
      n_bad++;
      $display("FAIL oe_on: got %h required %h", q, m_q);
    end
  endtask

  task automatic test_mid_clear();
    int cnt;
    rst_n = 1'b0;
    @(posedge ck);
    #1;
    rst_n = 1'b1;
    repeat (4) @(posedge ck);
    #1;
    n_cmp++;
    if (ready !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_clear_busy: got ready=%b required 0", ready);
    end
    rst_n = 1'b0;
    @(posedge ck);
    #1;
    rst_n = 1'b1;
    model_reset();
    cnt = 0;
    while (!ready && cnt < 20) begin
      @(posedge ck);
      #1;
      cnt++;
    end
    n_cmp++;
    if (cnt != 8) begin
      n_bad++;
      $display("FAIL mid_clear_length: got %0d cycles required 8", cnt);
    end
    for (int unsigned r = 0; r < RW; r++) begin
      do_op(1'b0, 0, '0, 1'b1, 1'b0, r);
      n_cmp++;
      if (q !== '0 || q_valid !== 1'b1) begin
        n_bad++;
        $display("FAIL post_clear_row%0d: got %h qv=%b required 0 1", r, q, q_valid);
      end
    end
  endtask

  initial begin
    test_reset();
    test_row_read();
    test_col_read();
    test_range_err();
    test_collision();
    test_random();
    test_oe();
    test_mid_clear();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
